// File: rtl/ahb_lite_master.sv
// rtl/ahb_lite_master.sv - AHB-Lite initiator running word INCR bursts from a valid/ready command port
module ahb_lite_master #(
  parameter int         LEN_W     = 8,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wd_valid,
  output logic             wd_ready,
  input  logic [31:0]      wd_data,
  output logic             rd_valid,
  output logic [31:0]      rd_data,
  output logic             done,
  output logic             err,
  output logic             HSEL,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic [3:0]       HPROT,
  output logic             HMASTLOCK,
  output logic [31:0]      HWDATA,
  input  logic [31:0]      HRDATA,
  input  logic             HREADY,
  input  logic             HRESP
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_LAST, ST_ERR2} state_t;

  localparam logic [1:0]       TR_IDLE   = 2'b00;
  localparam logic [1:0]       TR_NONSEQ = 2'b10;
  localparam logic [1:0]       TR_SEQ    = 2'b11;
  localparam logic [LEN_W-1:0] CNT_ONE   = LEN_W'(1);
  localparam logic [LEN_W-1:0] CNT_ZERO  = '0;

  state_t           state;
  logic [LEN_W-1:0] issue_cnt;
  logic [LEN_W-1:0] data_cnt;
  logic             need_ns;
  logic             held;
  logic             dp;
  logic             err_cyc;
  logic             offer;
  logic             accept;
  logic             dp_done;

  assign HSEL      = 1'b1;
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b001;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

  // First cycle of a two-cycle ERROR response; the pipelined beat is cancelled here.
  assign err_cyc = dp && !HREADY && HRESP;

  // A stalled write address phase stays offered even if wd_valid drops.
  assign offer   = (state == ST_RUN) && (issue_cnt != CNT_ZERO) &&
                   (!HWRITE || wd_valid || held) && !err_cyc;
  assign accept  = offer && HREADY;
  assign dp_done = dp && HREADY;

  assign HTRANS    = !offer ? TR_IDLE :
                     (need_ns || HADDR[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
  assign wd_ready  = accept && HWRITE;
  assign cmd_ready = (state == ST_IDLE);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HWDATA    <= '0;
      issue_cnt <= '0;
      data_cnt  <= '0;
      need_ns   <= 1'b0;
      held      <= 1'b0;
      dp        <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            HADDR     <= cmd_addr & ~32'h3;
            HWRITE    <= cmd_write;
            issue_cnt <= cmd_len;
            data_cnt  <= cmd_len;
            need_ns   <= 1'b1;
            held      <= 1'b0;
            dp        <= 1'b0;
            if (cmd_len == CNT_ZERO) done  <= 1'b1;
            else                     state <= ST_RUN;
          end
        end
        ST_RUN, ST_LAST: begin
          if (err_cyc) begin
            state <= ST_ERR2;
            held  <= 1'b0;
          end else begin
            held <= offer && !HREADY;
            if (HREADY) dp <= accept;
            if (accept) begin
              HADDR     <= HADDR + 32'd4;
              issue_cnt <= issue_cnt - CNT_ONE;
              need_ns   <= 1'b0;
              if (HWRITE) HWDATA <= wd_data;
              if (issue_cnt == CNT_ONE) state <= ST_LAST;
            end else if (!offer) begin
              need_ns <= 1'b1;
            end
            if (dp_done) begin
              data_cnt <= data_cnt - CNT_ONE;
              if (!HWRITE) begin
                rd_valid <= 1'b1;
                rd_data  <= HRDATA;
              end
              if (data_cnt == CNT_ONE) begin
                state <= ST_IDLE;
                done  <= 1'b1;
              end
            end
          end
        end
        ST_ERR2: begin
          if (HREADY) begin
            state <= ST_IDLE;
            dp    <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// tb/tb_ahb_lite_master.sv - directed cycle-scripted bench for ahb_lite_master
module tb_ahb_lite_master;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic        wd_valid = 1'b0;
  logic        wd_ready;
  logic [31:0] wd_data = '0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done;
  logic        err;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;

  ahb_lite_master #(.LEN_W(8), .HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  int          n_chk = 0;
  int          n_bad = 0;
  logic [31:0] wsrc [4] = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};
  int          widx = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] rq [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus(input string tag, input logic [1:0] tr, input logic [31:0] a);
    chk({tag, "_htrans"}, {30'd0, HTRANS}, {30'd0, tr});
    if (tr != T_IDLE) chk({tag, "_haddr"}, HADDR, a);
  endtask

  // One bus cycle: drive at the falling edge, sample 1ns later, log stream activity.
  task automatic tick(input logic cv, input logic rdy, input logic resp,
                      input logic [31:0] rdata, input logic wv);
    @(negedge HCLK);
    cmd_valid = cv;
    HREADY    = rdy;
    HRESP     = resp;
    HRDATA    = rdata;
    wd_valid  = wv;
    wd_data   = wsrc[widx];
    #1;
    if (rd_valid) rq.push_back(rd_data);
    if (wd_ready) begin
      wr_cnt++;
      if (widx < 3) widx++;
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
  endtask

  task automatic clr();
    widx = 0; wr_cnt = 0; done_cnt = 0; err_cnt = 0;
    rq.delete();
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [7:0] l);
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    tick(1'b1, 1'b1, 1'b0, 32'h0, w);
    chk("cmd_ready_at_issue", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic idle();
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    @(negedge HCLK);
    #1;
    chk("rst_htrans", {30'd0, HTRANS}, 32'd0);
    chk("rst_haddr", HADDR, 32'd0);
    chk("rst_hwrite", {31'd0, HWRITE}, 32'd0);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_wd_ready", {31'd0, wd_ready}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge HCLK);
    HRESETn = 1'b1;
    idle();
    chk("const_hsel", {31'd0, HSEL}, 32'd1);
    chk("const_hsize", {29'd0, HSIZE}, 32'd2);
    chk("const_hburst", {29'd0, HBURST}, 32'd1);
    chk("const_hprot", {28'd0, HPROT}, 32'd3);
    chk("const_hmastlock", {31'd0, HMASTLOCK}, 32'd0);

    // single zero-wait read
    clr();
    issue(1'b0, 32'h2000_0010, 8'd1);
    idle();
    bus("t1_w1", T_NSEQ, 32'h2000_0010);
    chk("t1_hwrite", {31'd0, HWRITE}, 32'd0);
    chk("t1_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
    tick(1'b0, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b0);
    bus("t1_w2", T_IDLE, 32'h0);
    chk("t1_rd_valid_early", {31'd0, rd_valid}, 32'd0);
    idle();
    chk("t1_rd_valid", {31'd0, rd_valid}, 32'd1);
    chk("t1_rd_data", rd_data, 32'hCAFE_F00D);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_err", {31'd0, err}, 32'd0);
    idle();
    chk("t1_done_pulse", {31'd0, done}, 32'd0);
    chk("t1_back_idle", {31'd0, cmd_ready}, 32'd1);

    // 4-beat write with continuous write data
    clr();
    issue(1'b1, 32'h2000_0000, 8'd4);
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    bus("t2_w1", T_NSEQ, 32'h2000_0000);
    chk("t2_hwrite", {31'd0, HWRITE}, 32'd1);
    chk("t2_wd_ready1", {31'd0, wd_ready}, 32'd1);
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    bus("t2_w2", T_SEQ, 32'h2000_0004);
    chk("t2_hwdata0", HWDATA, 32'hA0A0_0001);
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    bus("t2_w3", T_SEQ, 32'h2000_0008);
    chk("t2_hwdata1", HWDATA, 32'hB1B1_0002);
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    bus("t2_w4", T_SEQ, 32'h2000_000C);
    chk("t2_hwdata2", HWDATA, 32'hC2C2_0003);
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    bus("t2_w5", T_IDLE, 32'h0);
    chk("t2_hwdata3", HWDATA, 32'hD3D3_0004);
    chk("t2_not_done_yet", {31'd0, done}, 32'd0);
    idle();
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_wr_cnt", wr_cnt, 32'd4);
    chk("t2_no_err", err_cnt, 32'd0);

    // write with a two-cycle gap in the data stream
    clr();
    issue(1'b1, 32'h2000_0100, 8'd3);
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    bus("t3_w1", T_NSEQ, 32'h2000_0100);
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    bus("t3_w2", T_IDLE, 32'h0);
    chk("t3_wd_ready_gap", {31'd0, wd_ready}, 32'd0);
    chk("t3_hwdata0", HWDATA, 32'hA0A0_0001);
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    bus("t3_w3", T_IDLE, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    bus("t3_w4", T_NSEQ, 32'h2000_0104);
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    bus("t3_w5", T_SEQ, 32'h2000_0108);
    chk("t3_hwdata1", HWDATA, 32'hB1B1_0002);
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    bus("t3_w6", T_IDLE, 32'h0);
    chk("t3_hwdata2", HWDATA, 32'hC2C2_0003);
    idle();
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_wr_cnt", wr_cnt, 32'd3);

    // read across a 1KB boundary with two wait states on beat 2
    clr();
    issue(1'b0, 32'h2000_03F8, 8'd4);
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    bus("t4_w1", T_NSEQ, 32'h2000_03F8);
    tick(1'b0, 1'b1, 1'b0, 32'h1111_0001, 1'b0);
    bus("t4_w2", T_SEQ, 32'h2000_03FC);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    bus("t4_w3", T_NSEQ, 32'h2000_0400);
    chk("t4_rd_valid_b1", {31'd0, rd_valid}, 32'd1);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    bus("t4_w4_hold", T_NSEQ, 32'h2000_0400);
    chk("t4_rd_valid_wait", {31'd0, rd_valid}, 32'd0);
    tick(1'b0, 1'b1, 1'b0, 32'h2222_0002, 1'b0);
    bus("t4_w5_hold", T_NSEQ, 32'h2000_0400);
    tick(1'b0, 1'b1, 1'b0, 32'h3333_0003, 1'b0);
    bus("t4_w6", T_SEQ, 32'h2000_0404);
    tick(1'b0, 1'b1, 1'b0, 32'h4444_0004, 1'b0);
    bus("t4_w7", T_IDLE, 32'h0);
    idle();
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_rd_count", rq.size(), 32'd4);
    if (rq.size() == 4) begin
      chk("t4_rd0", rq[0], 32'h1111_0001);
      chk("t4_rd1", rq[1], 32'h2222_0002);
      chk("t4_rd2", rq[2], 32'h3333_0003);
      chk("t4_rd3", rq[3], 32'h4444_0004);
    end

    // read of 8 with ERROR on beat 3
    clr();
    issue(1'b0, 32'h2000_1000, 8'd8);
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    bus("t5_w1", T_NSEQ, 32'h2000_1000);
    tick(1'b0, 1'b1, 1'b0, 32'h5555_0001, 1'b0);
    bus("t5_w2", T_SEQ, 32'h2000_1004);
    tick(1'b0, 1'b1, 1'b0, 32'h6666_0002, 1'b0);
    bus("t5_w3", T_SEQ, 32'h2000_1008);
    tick(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    bus("t5_err1_cancel", T_IDLE, 32'h0);
    tick(1'b0, 1'b1, 1'b1, 32'h0, 1'b0);
    bus("t5_err2", T_IDLE, 32'h0);
    chk("t5_done_early", {31'd0, done}, 32'd0);
    idle();
    chk("t5_done", {31'd0, done}, 32'd1);
    chk("t5_err", {31'd0, err}, 32'd1);
    chk("t5_rd_valid_err_beat", {31'd0, rd_valid}, 32'd0);
    chk("t5_rd_count", rq.size(), 32'd2);
    if (rq.size() == 2) begin
      chk("t5_rd0", rq[0], 32'h5555_0001);
      chk("t5_rd1", rq[1], 32'h6666_0002);
    end

    // zero-length command right after the error
    clr();
    issue(1'b0, 32'h3000_0000, 8'd0);
    bus("t6_w0", T_IDLE, 32'h0);
    idle();
    chk("t6_len0_done", {31'd0, done}, 32'd1);
    chk("t6_len0_err", {31'd0, err}, 32'd0);
    bus("t6_w1", T_IDLE, 32'h0);
    idle();
    chk("t6_len0_done_pulse", done_cnt, 32'd1);

    // reset asserted mid-burst
    clr();
    issue(1'b0, 32'h2000_2000, 8'd4);
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    bus("t7_w1", T_NSEQ, 32'h2000_2000);
    tick(1'b0, 1'b1, 1'b0, 32'h7777_0001, 1'b0);
    bus("t7_w2", T_SEQ, 32'h2000_2004);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("t7_async_htrans", {30'd0, HTRANS}, 32'd0);
    chk("t7_async_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("t7_async_haddr", HADDR, 32'd0);
    tick(1'b0, 1'b1, 1'b0, 32'h7777_0002, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 32'h7777_0003, 1'b0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    idle();
    idle();
    chk("t7_no_done", done_cnt, 32'd0);
    chk("t7_no_rd", rq.size(), 32'd0);
    chk("t7_idle_after", {31'd0, cmd_ready}, 32'd1);
    bus("t7_bus_idle", T_IDLE, 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
